// File: rtl/change_hopper_if.sv
// Signal bundle between the vending FSM's change outputs, the hopper pins and the hopper controller.
// The master side drives codes and sensor inputs; the slave side is the controller.
interface change_hopper_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]    i_change_code;
    logic          i_change_valid;
    logic          i_no_change;
    logic          i_coin_sense;
    logic          i_err_clear;
    logic [3:0]    o_hopper_sel;
    logic          o_hopper_fire;
    logic          o_ready;
    logic          o_idle;
    logic          o_jam;
    logic [3:0]    o_jam_code;
    logic          o_overflow;
    logic          o_no_change_err;
    logic [CW-1:0] o_fifo_count;
    logic [15:0]   o_dispensed_cnt;

    modport master (
        output i_change_code, i_change_valid, i_no_change, i_coin_sense, i_err_clear,
        input  o_hopper_sel, o_hopper_fire, o_ready, o_idle, o_jam, o_jam_code,
               o_overflow, o_no_change_err, o_fifo_count, o_dispensed_cnt
    );

    modport slave (
        input  i_change_code, i_change_valid, i_no_change, i_coin_sense, i_err_clear,
        output o_hopper_sel, o_hopper_fire, o_ready, o_idle, o_jam, o_jam_code,
               o_overflow, o_no_change_err, o_fifo_count, o_dispensed_cnt
    );
endinterface

// File: rtl/change_hopper_ctrl.sv
// Change hopper sequencer: buffers change codes, fires one hopper at a time, waits for the
// exit sensor, retries on timeout and latches a jam when the retries are exhausted.
module change_hopper_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int RETRY_MAX      = 2,
    parameter int GAP_CYCLES     = 2
) (
    input logic            i_clk,
    input logic            i_rst_n,
    change_hopper_if.slave hop
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int MAX_A = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int MAX_T = (TIMEOUT_CYCLES > MAX_A) ? TIMEOUT_CYCLES : MAX_A;
    localparam int TW    = (MAX_T < 2) ? 1 : $clog2(MAX_T);
    localparam int RW    = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRE,
        S_WAIT_COIN,
        S_GAP,
        S_JAM
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cur_code_q, cur_code_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;

    logic          fire_q, jam_q, overflow_q, no_change_err_q;
    logic [3:0]    sel_q, jam_code_q;
    logic [15:0]   dispensed_q, dispensed_d;

    logic          pop, push_req, push_ok, ovf_set, nce_set, coin_ok;
    logic          fire_d, jam_d, overflow_d, no_change_err_d;
    logic [3:0]    sel_d, jam_code_d;

    // A push into a full FIFO still fits when the FSM pops in the same cycle.
    always_comb begin
        push_req = hop.i_change_valid & ~hop.i_no_change & (hop.i_change_code != 4'd0);
        push_ok  = push_req & ((count_q != CW'(FIFO_DEPTH)) | pop);
        ovf_set  = push_req & ~push_ok;
        nce_set  = hop.i_change_valid & hop.i_no_change;
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cur_code_d = cur_code_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        pop        = 1'b0;
        coin_ok    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    cur_code_d = mem[rd_ptr_q];
                    retry_d    = '0;
                    timer_d    = '0;
                    state_d    = S_FIRE;
                end
            end
            S_FIRE: begin
                if (timer_q == TW'(PULSE_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = S_WAIT_COIN;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_COIN: begin
                // A sensor pulse in the final timeout cycle still counts as a dispense.
                if (hop.i_coin_sense) begin
                    coin_ok = 1'b1;
                    timer_d = '0;
                    state_d = S_GAP;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    timer_d = '0;
                    if (retry_q < RW'(RETRY_MAX)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_FIRE;
                    end else begin
                        state_d = S_JAM;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_GAP: begin
                if (timer_q == TW'(GAP_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_JAM: begin
                if (hop.i_err_clear) begin
                    cur_code_d = 4'd0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs follow the next state so they change on the same edge as the FSM.
    always_comb begin
        fire_d          = (state_d == S_FIRE);
        sel_d           = fire_d ? cur_code_d : 4'd0;
        jam_d           = (state_d == S_JAM);
        jam_code_d      = jam_d ? cur_code_d : 4'd0;
        overflow_d      = ovf_set | (overflow_q & ~hop.i_err_clear);
        no_change_err_d = nce_set | (no_change_err_q & ~hop.i_err_clear);
        dispensed_d     = dispensed_q + {15'd0, coin_ok};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= S_IDLE;
            cur_code_q      <= 4'd0;
            timer_q         <= '0;
            retry_q         <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            fire_q          <= 1'b0;
            sel_q           <= 4'd0;
            jam_q           <= 1'b0;
            jam_code_q      <= 4'd0;
            overflow_q      <= 1'b0;
            no_change_err_q <= 1'b0;
            dispensed_q     <= 16'd0;
        end else begin
            state_q         <= state_d;
            cur_code_q      <= cur_code_d;
            timer_q         <= timer_d;
            retry_q         <= retry_d;
            count_q         <= count_d;
            fire_q          <= fire_d;
            sel_q           <= sel_d;
            jam_q           <= jam_d;
            jam_code_q      <= jam_code_d;
            overflow_q      <= overflow_d;
            no_change_err_q <= no_change_err_d;
            dispensed_q     <= dispensed_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= hop.i_change_code;
        end
    end

    assign hop.o_hopper_fire   = fire_q;
    assign hop.o_hopper_sel    = sel_q;
    assign hop.o_jam           = jam_q;
    assign hop.o_jam_code      = jam_code_q;
    assign hop.o_overflow      = overflow_q;
    assign hop.o_no_change_err = no_change_err_q;
    assign hop.o_fifo_count    = count_q;
    assign hop.o_dispensed_cnt = dispensed_q;
    assign hop.o_ready         = (count_q != CW'(FIFO_DEPTH));
    assign hop.o_idle          = (state_q == S_IDLE) && (count_q == '0);
endmodule

// File: tb/tb_change_hopper_ctrl.sv
// Self-checking bench for change_hopper_ctrl: scoreboard of expected hopper codes checked at
// every fire pulse, a flag/FIFO vector table applied during JAM, and hand-written corner cases.
module tb_change_hopper_ctrl;
    localparam int FIFO_DEPTH = 8;
    localparam int PULSE      = 4;
    localparam int TIMEOUT    = 1000;
    localparam int RETRIES    = 2;
    localparam int GAP        = 2;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   exp_disp = 0;
    int   cyc      = 0;
    bit   auto_sense = 1'b0;
    logic [3:0] sb_q[$];
    int   rise_cyc[$];

    change_hopper_if #(.FIFO_DEPTH(FIFO_DEPTH)) hop_if ();

    change_hopper_ctrl #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .PULSE_CYCLES  (PULSE),
        .TIMEOUT_CYCLES(TIMEOUT),
        .RETRY_MAX     (RETRIES),
        .GAP_CYCLES    (GAP)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .hop    (hop_if.slave)
    );

    typedef struct {
        logic       valid;
        logic       no_change;
        logic [3:0] code;
        logic       err_clear;
        int         exp_count;
        logic       exp_ovf;
        logic       exp_nce;
        logic       exp_jam;
        logic [3:0] sb_code;
        logic       drop_jam;
    } vec_t;

    vec_t vecs[15];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        hop_if.i_change_valid = v.valid;
        hop_if.i_no_change    = v.no_change;
        hop_if.i_change_code  = v.code;
        hop_if.i_err_clear    = v.err_clear;
        if (v.sb_code != 4'd0) sb_q.push_back(v.sb_code);
        if (v.drop_jam && sb_q.size() > 0) void'(sb_q.pop_front());
    endtask

    task automatic clear_inputs();
        hop_if.i_change_valid = 1'b0;
        hop_if.i_no_change    = 1'b0;
        hop_if.i_change_code  = 4'd0;
        hop_if.i_err_clear    = 1'b0;
    endtask

    task automatic push_code(input logic [3:0] code, input bit expect_accept);
        hop_if.i_change_valid = 1'b1;
        hop_if.i_no_change    = 1'b0;
        hop_if.i_change_code  = code;
        if (expect_accept) sb_q.push_back(code);
    endtask

    task automatic do_reset();
        auto_sense = 1'b0;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sb_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int max_cycles);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (hop_if.o_idle && sb_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("wait_idle", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_jam(input int max_cycles);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (hop_if.o_jam) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("wait_jam", {31'd0, done}, 32'd1);
    endtask

    // Pulse monitor and coin-sensor responder; samples 1 ns after each rising edge.
    initial begin
        logic prev_fire;
        int   len;
        int   sense_dly;
        prev_fire = 1'b0;
        len       = 0;
        sense_dly = -1;
        hop_if.i_coin_sense = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            hop_if.i_coin_sense = 1'b0;
            if (!rst_n) begin
                prev_fire = 1'b0;
                len       = 0;
                sense_dly = -1;
            end else begin
                if (hop_if.o_hopper_fire && !prev_fire) begin
                    len = 1;
                    rise_cyc.push_back(cyc);
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("[TB] FAIL pulse_unexpected: got sel 0x%0h, expected no pulse", hop_if.o_hopper_sel);
                    end else begin
                        checkOutput("pulse_sel", {28'd0, hop_if.o_hopper_sel}, {28'd0, sb_q[0]});
                    end
                end else if (hop_if.o_hopper_fire) begin
                    len++;
                end else if (prev_fire) begin
                    checkOutput("pulse_len", len, PULSE);
                    checkOutput("sel_after_pulse", {28'd0, hop_if.o_hopper_sel}, 32'd0);
                    if (auto_sense) sense_dly = 5;
                end
                if (sense_dly > 0) begin
                    sense_dly--;
                end else if (sense_dly == 0) begin
                    sense_dly = -1;
                    hop_if.i_coin_sense = 1'b1;
                    exp_disp++;
                    if (sb_q.size() > 0) void'(sb_q.pop_front());
                end
                prev_fire = hop_if.o_hopper_fire;
            end
        end
    end

    initial begin
        int n0;
        bit got_fire;
        // Applied while jammed on code 6 with an empty FIFO, so the FSM never pops until the clear.
        vecs[0]  = '{1'b1, 1'b0, 4'd2,  1'b0, 1, 1'b0, 1'b0, 1'b1, 4'd2,  1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1, 1'b0, 1'b0, 1'b1, 4'd0,  1'b0};
        vecs[2]  = '{1'b1, 1'b1, 4'd0,  1'b0, 1, 1'b0, 1'b1, 1'b1, 4'd0,  1'b0};
        vecs[3]  = '{1'b1, 1'b0, 4'd7,  1'b0, 2, 1'b0, 1'b1, 1'b1, 4'd7,  1'b0};
        vecs[4]  = '{1'b1, 1'b0, 4'd1,  1'b0, 3, 1'b0, 1'b1, 1'b1, 4'd1,  1'b0};
        vecs[5]  = '{1'b1, 1'b0, 4'd4,  1'b0, 4, 1'b0, 1'b1, 1'b1, 4'd4,  1'b0};
        vecs[6]  = '{1'b1, 1'b0, 4'd5,  1'b0, 5, 1'b0, 1'b1, 1'b1, 4'd5,  1'b0};
        vecs[7]  = '{1'b1, 1'b0, 4'd8,  1'b0, 6, 1'b0, 1'b1, 1'b1, 4'd8,  1'b0};
        vecs[8]  = '{1'b1, 1'b0, 4'd11, 1'b0, 7, 1'b0, 1'b1, 1'b1, 4'd11, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 4'd12, 1'b0, 8, 1'b0, 1'b1, 1'b1, 4'd12, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 4'd13, 1'b0, 8, 1'b1, 1'b1, 1'b1, 4'd0,  1'b0};
        vecs[11] = '{1'b0, 1'b0, 4'd0,  1'b0, 8, 1'b1, 1'b1, 1'b1, 4'd0,  1'b0};
        vecs[12] = '{1'b1, 1'b1, 4'd0,  1'b1, 8, 1'b0, 1'b1, 1'b0, 4'd0,  1'b1};
        vecs[13] = '{1'b1, 1'b0, 4'd14, 1'b0, 8, 1'b0, 1'b1, 1'b0, 4'd14, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 4'd0,  1'b1, 8, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0};

        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_fire",     {31'd0, hop_if.o_hopper_fire}, 32'd0);
        checkOutput("rst_sel",      {28'd0, hop_if.o_hopper_sel}, 32'd0);
        checkOutput("rst_ready",    {31'd0, hop_if.o_ready}, 32'd1);
        checkOutput("rst_idle",     {31'd0, hop_if.o_idle}, 32'd1);
        checkOutput("rst_jam",      {31'd0, hop_if.o_jam}, 32'd0);
        checkOutput("rst_overflow", {31'd0, hop_if.o_overflow}, 32'd0);
        checkOutput("rst_nce",      {31'd0, hop_if.o_no_change_err}, 32'd0);
        checkOutput("rst_count",    {28'd0, hop_if.o_fifo_count}, 32'd0);
        checkOutput("rst_disp",     {16'd0, hop_if.o_dispensed_cnt}, 32'd0);

        // Three codes back-to-back, sensor answers each pulse.
        auto_sense = 1'b1;
        push_code(4'd3, 1'b1);
        @(negedge clk);
        push_code(4'd9, 1'b1);
        @(negedge clk);
        checkOutput("latency_fire", {31'd0, hop_if.o_hopper_fire}, 32'd1);
        checkOutput("latency_sel",  {28'd0, hop_if.o_hopper_sel}, 32'd3);
        push_code(4'd15, 1'b1);
        @(negedge clk);
        clear_inputs();
        wait_idle(2000);
        checkOutput("three_disp", {16'd0, hop_if.o_dispensed_cnt}, 32'd3);
        checkOutput("three_disp_model", {16'd0, hop_if.o_dispensed_cnt}, exp_disp);
        checkOutput("three_idle", {31'd0, hop_if.o_idle}, 32'd1);

        // No sensor: first pulse plus two retries, then jam.
        auto_sense = 1'b0;
        n0 = rise_cyc.size();
        push_code(4'd6, 1'b1);
        @(negedge clk);
        clear_inputs();
        wait_jam(4000);
        checkOutput("jam_flag",   {31'd0, hop_if.o_jam}, 32'd1);
        checkOutput("jam_code",   {28'd0, hop_if.o_jam_code}, 32'd6);
        checkOutput("jam_pulses", rise_cyc.size() - n0, 32'd3);
        if (rise_cyc.size() >= n0 + 3) begin
            checkOutput("retry_space1", rise_cyc[n0+1] - rise_cyc[n0], PULSE + TIMEOUT);
            checkOutput("retry_space2", rise_cyc[n0+2] - rise_cyc[n0+1], PULSE + TIMEOUT);
        end
        repeat (20) @(negedge clk);
        checkOutput("jam_no_fire", {31'd0, hop_if.o_hopper_fire}, 32'd0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_count", i), {28'd0, hop_if.o_fifo_count}, vecs[i].exp_count);
            checkOutput($sformatf("vec%0d_ovf", i), {31'd0, hop_if.o_overflow}, {31'd0, vecs[i].exp_ovf});
            checkOutput($sformatf("vec%0d_nce", i), {31'd0, hop_if.o_no_change_err}, {31'd0, vecs[i].exp_nce});
            checkOutput($sformatf("vec%0d_jam", i), {31'd0, hop_if.o_jam}, {31'd0, vecs[i].exp_jam});
            checkOutput($sformatf("vec%0d_ready", i), {31'd0, hop_if.o_ready},
                        (vecs[i].exp_count != FIFO_DEPTH) ? 32'd1 : 32'd0);
        end
        clear_inputs();
        auto_sense = 1'b1;
        wait_idle(1000);
        checkOutput("after_jam_disp", {16'd0, hop_if.o_dispensed_cnt}, 32'd12);
        checkOutput("after_jam_model", {16'd0, hop_if.o_dispensed_cnt}, exp_disp);

        // Asynchronous reset in the second FIRE cycle.
        auto_sense = 1'b0;
        push_code(4'd5, 1'b1);
        @(negedge clk);
        clear_inputs();
        got_fire = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (hop_if.o_hopper_fire) begin
                got_fire = 1'b1;
                break;
            end
        end
        checkOutput("fire_before_reset", {31'd0, got_fire}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_fire", {31'd0, hop_if.o_hopper_fire}, 32'd0);
        checkOutput("async_rst_sel",  {28'd0, hop_if.o_hopper_sel}, 32'd0);
        repeat (2) @(negedge clk);
        sb_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_count", {28'd0, hop_if.o_fifo_count}, 32'd0);
        checkOutput("post_rst_disp",  {16'd0, hop_if.o_dispensed_cnt}, 32'd0);
        checkOutput("post_rst_ready", {31'd0, hop_if.o_ready}, 32'd1);
        checkOutput("post_rst_idle",  {31'd0, hop_if.o_idle}, 32'd1);

        // Ten codes back-to-back: one popped, eight held, the tenth dropped.
        for (int k = 1; k <= 10; k++) begin
            push_code(4'(k), k <= 9);
            @(negedge clk);
            if (k == 9) begin
                checkOutput("full_count", {28'd0, hop_if.o_fifo_count}, 32'd8);
                checkOutput("full_ready", {31'd0, hop_if.o_ready}, 32'd0);
                checkOutput("full_no_ovf", {31'd0, hop_if.o_overflow}, 32'd0);
            end
        end
        clear_inputs();
        checkOutput("ovf_count", {28'd0, hop_if.o_fifo_count}, 32'd8);
        checkOutput("ovf_flag",  {31'd0, hop_if.o_overflow}, 32'd1);
        do_reset();
        checkOutput("ovf_cleared_by_rst", {31'd0, hop_if.o_overflow}, 32'd0);

        // Dispense counter wrap.
        auto_sense = 1'b1;
        force dut.dispensed_q = 16'hFFFF;
        #1;
        release dut.dispensed_q;
        @(negedge clk);
        checkOutput("preload_disp", {16'd0, hop_if.o_dispensed_cnt}, 32'h0000_FFFF);
        push_code(4'd11, 1'b1);
        @(negedge clk);
        clear_inputs();
        wait_idle(500);
        checkOutput("wrap_disp", {16'd0, hop_if.o_dispensed_cnt}, 32'd0);
        checkOutput("wrap_idle", {31'd0, hop_if.o_idle}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
